// File: rtl/top_scr_brd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : top_scr_brd
// Purpose  : Iterative AES-128 block decryptor with a chaining XOR on the
//            output. The round keys are expanded one per cycle, then the
//            inverse cipher runs one round per cycle. The result is
//            InvCipher(cipher, key) ^ C.
// Ports    : clk        - single clock, rising edge
//            rst        - asynchronous, active-low reset
//            start      - request to decrypt one block (sampled in IDLE only)
//            Iv         - 64-bit initialisation vector, used as {Iv, Iv}
//            cipher     - 128-bit ciphertext block (FIPS-197 byte order)
//            key        - 128-bit AES key
//            plain_text - decrypted block, held until the next result
//            ready      - plain_text valid; drops when a new start is accepted
// Options  : TOP_SCR_BRD_CBC_CHAIN_EN - when defined, blocks after the first
//            one following reset are XORed with the previously captured
//            ciphertext instead of {Iv, Iv}.
// Revision : 1.0 - initial release
// ============================================================================
module top_scr_brd #(
    parameter int Nb = 4,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       Iv,
    input  logic [32*Nb-1:0]  cipher,
    input  logic [32*Nk-1:0]  key,
    output logic [127:0]      plain_text,
    output logic              ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2
    } state_t;

    localparam logic [3:0] c_nr         = 4'(Nr);
    localparam logic [3:0] c_last_round = 4'(Nr - 1);

    // ---------------------------------------------------------------- GF(2^8)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // S-boxes computed from the field inverse and the affine map rather
    // than stored as tables.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------------------------------------------------------- storage
    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [3:0]     r_cnt;
    logic [127:0]   r_blk;
    logic [127:0]   r_rk [0:Nr];
    logic [127:0]   w_chain;

    logic           w_accept;
    logic           w_kexp;
    logic           w_round;
    logic           w_finish;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fsm <= IDLE;
        else      r_fsm <= w_fsm_nxt;
    end

    // ROUND spends Nr cycles on rounds and one more cycle (r_cnt == Nr)
    // registering the chained result, so ready rises 21 edges after start.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_accept  = 1'b0;
        w_kexp    = 1'b0;
        w_round   = 1'b0;
        w_finish  = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (start) begin
                    w_accept  = 1'b1;
                    w_fsm_nxt = KEYEXP;
                end
            end
            KEYEXP: begin
                w_kexp = 1'b1;
                if (r_cnt == c_last_round) w_fsm_nxt = ROUND;
            end
            ROUND: begin
                if (r_cnt == c_nr) begin
                    w_finish  = 1'b1;
                    w_fsm_nxt = IDLE;
                end else begin
                    w_round = 1'b1;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- key schedule
    logic [127:0] w_prev_rk;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub_w;
    logic [127:0] w_key_nxt;

    always_comb begin
        w_prev_rk  = r_rk[r_cnt];
        w_rot      = {w_prev_rk[23:0], w_prev_rk[31:24]};
        w_sub_w    = {sbox(w_rot[31:24]) ^ rcon(r_cnt), sbox(w_rot[23:16]),
                      sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_key_nxt[127:96] = w_prev_rk[127:96] ^ w_sub_w;
        w_key_nxt[95:64]  = w_prev_rk[95:64]  ^ w_key_nxt[127:96];
        w_key_nxt[63:32]  = w_prev_rk[63:32]  ^ w_key_nxt[95:64];
        w_key_nxt[31:0]   = w_prev_rk[31:0]   ^ w_key_nxt[63:32];
    end

    // ---------------------------------------------------------------- inverse round
    logic [3:0]   w_rk_idx;
    logic [127:0] w_pre;
    logic [127:0] w_sub;
    logic [127:0] w_ark;
    logic [127:0] w_mix;
    logic [127:0] w_rnd;

    always_comb begin
        w_rk_idx = (r_cnt <= c_last_round) ? (c_last_round - r_cnt) : 4'd0;
        // The first round also folds in the initial AddRoundKey with key Nr.
        w_pre    = (r_cnt == 4'd0) ? (r_blk ^ r_rk[Nr]) : r_blk;
        w_sub    = '0;
        w_mix    = '0;
        // Byte n sits at row n%4, column n/4; row r rotates right by r.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_sub[127-8*(r+4*c) -: 8] = inv_sbox(w_pre[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        w_ark = w_sub ^ r_rk[w_rk_idx];
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
        end
        w_rnd = (r_cnt == c_last_round) ? w_ark : w_mix;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 4'd0;
            r_blk      <= '0;
            plain_text <= '0;
            ready      <= 1'b0;
            for (int i = 0; i <= Nr; i++) r_rk[i] <= '0;
        end else begin
            if (w_accept) begin
                r_blk   <= cipher;
                r_rk[0] <= key;
                ready   <= 1'b0;
                r_cnt   <= 4'd0;
            end
            if (w_kexp) begin
                r_rk[r_cnt + 4'd1] <= w_key_nxt;
                r_cnt <= (r_cnt == c_last_round) ? 4'd0 : r_cnt + 4'd1;
            end
            if (w_round) begin
                r_blk <= w_rnd;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_finish) begin
                plain_text <= r_blk ^ w_chain;
                ready      <= 1'b1;
                r_cnt      <= 4'd0;
            end
        end
    end

    // ---------------------------------------------------------------- chaining value
`ifdef TOP_SCR_BRD_CBC_CHAIN_EN
    logic         r_first;
    logic [127:0] r_prev_ct;
    logic [127:0] r_chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first   <= 1'b1;
            r_prev_ct <= '0;
            r_chain   <= '0;
        end else if (w_accept) begin
            r_chain   <= r_first ? {Iv, Iv} : r_prev_ct;
            r_prev_ct <= cipher;
            r_first   <= 1'b0;
        end
    end

    assign w_chain = r_chain;
`else
    logic [63:0] r_iv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_iv <= '0;
        else if (w_accept) r_iv <= Iv;
    end

    assign w_chain = {r_iv, r_iv};
`endif

endmodule
`default_nettype wire

// File: tb/tb_top_scr_brd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_top_scr_brd
// Purpose  : Scoreboard bench for top_scr_brd. Stimulus pushes the expected
//            plain_text and the edge on which ready must rise; a monitor pops
//            and compares on each rising ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_top_scr_brd;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] P1_IV = 128'h2223a7a501454474aaab2f2d89cdccfc;
    localparam logic [63:0]  IV1 = 64'h2232859645102203;
    localparam int LATENCY = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  Iv;
    logic [127:0] cipher;
    logic [127:0] key;
    logic [127:0] plain_text;
    logic         ready;

    top_scr_brd dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .Iv         (Iv),
        .cipher     (cipher),
        .key        (key),
        .plain_text (plain_text),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           edge_no;
    } exp_t;

    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] last_pt  = '0;

`ifdef TOP_SCR_BRD_CBC_CHAIN_EN
    logic         m_first = 1'b1;
    logic [127:0] m_prev  = '0;
`endif

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Chaining value the block should apply to the next accepted start.
    task automatic model_chain(input logic [127:0] c, input logic [63:0] iv,
                               output logic [127:0] ch);
`ifdef TOP_SCR_BRD_CBC_CHAIN_EN
        ch      = m_first ? {iv, iv} : m_prev;
        m_first = 1'b0;
        m_prev  = c;
`else
        ch = {iv, iv};
        if (c === 'x) ch = 'x;
`endif
    endtask

    // Monitor: every rising ready must match the oldest expectation.
    logic mon_prev_ready = 1'b0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (ready === 1'b1 && mon_prev_ready !== 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_ready: ready rose at edge %0d, none expected", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk128("result", plain_text, mon_e.pt);
                chk_int("ready_edge", cyc, mon_e.edge_no);
                last_pt = mon_e.pt;
            end
        end
        mon_prev_ready = ready;
    end

    task automatic issue(input logic [127:0] c, input logic [127:0] k,
                         input logic [63:0] iv, input logic [127:0] p);
        logic [127:0] ch;
        exp_t         e;
        @(negedge clk);
        cipher = c;
        key    = k;
        Iv     = iv;
        start  = 1'b1;
        model_chain(c, iv, ch);
        e.pt      = p ^ ch;
        e.edge_no = cyc + 1 + LATENCY;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk_int("ready_low_after_accept", int'(ready), 0);
        chk128("plain_text_held_after_accept", plain_text, last_pt);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: %0d results pending after %0d cycles", sb_q.size(), budget);
            sb_q.delete();
        end
    endtask

    // Asserts reset at the current time, holds it, checks outputs, releases.
    task automatic do_reset(input int cycles);
        rst = 1'b0;
        sb_q.delete();
        last_pt = '0;
`ifdef TOP_SCR_BRD_CBC_CHAIN_EN
        m_first = 1'b1;
`endif
        repeat (cycles) @(negedge clk);
        chk_int("reset_ready", int'(ready), 0);
        chk128("reset_plain_text", plain_text, '0);
        rst   = 1'b1;
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] ch1;
        logic [127:0] ch2;
        exp_t         e;

        // Reset with start held high: nothing must happen.
        rst    = 1'b0;
        start  = 1'b1;
        cipher = C1;
        key    = K1;
        Iv     = '1;
        do_reset(3);
        repeat (25) @(negedge clk);
        chk_int("idle_after_reset_ready", int'(ready), 0);

        // Known-answer block, Iv = 0.
        issue(C1, K1, 64'h0, P1);
        wait_done(60);

        // Iv test as the first block after reset (same C in both builds).
        @(negedge clk);
        do_reset(2);
        issue(C1, K1, IV1, P1);
        wait_done(60);
        chk128("iv_kat", plain_text, P1_IV);

        // Second vector with another Iv.
        issue(C2, K2, 64'h0123456789abcdef, P2);
        wait_done(60);

        // Busy: re-pulse start and change inputs during KEYEXP and ROUND.
        issue(C1, K1, 64'h55aa55aa0f0f0f0f, P1);
        repeat (3) @(negedge clk);
        start = 1'b1; cipher = C2; key = K2; Iv = 64'hdeadbeefcafef00d;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; cipher = ~C1; key = ~K1; Iv = 64'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        repeat (30) @(negedge clk);
        chk_int("busy_ready_holds", int'(ready), 1);
        chk128("busy_result_holds", plain_text, last_pt);

        // Reset at cycle 12 of an operation: result must never appear.
        issue(C1, K1, IV1, P1);
        repeat (11) @(negedge clk);
        do_reset(3);
        repeat (30) @(negedge clk);
        chk_int("aborted_no_ready", int'(ready), 0);
        issue(C2, K2, IV1, P2);
        wait_done(60);

        // start held high across two operations.
        @(negedge clk);
        cipher = C2; key = K2; Iv = 64'h0f1e2d3c4b5a6978; start = 1'b1;
        model_chain(C2, Iv, ch1);
        e.pt = P2 ^ ch1; e.edge_no = cyc + 1 + LATENCY;
        sb_q.push_back(e);
        model_chain(C2, Iv, ch2);
        e.pt = P2 ^ ch2; e.edge_no = cyc + 1 + LATENCY + 22;
        sb_q.push_back(e);
        repeat (23) @(negedge clk);
        start = 1'b0;
        chk_int("back_to_back_ready_low", int'(ready), 0);
        chk128("back_to_back_old_result", plain_text, P2 ^ ch1);
        wait_done(60);

        // Two identical blocks after reset with Iv = 0.
        @(negedge clk);
        do_reset(2);
        issue(C1, K1, 64'h0, P1);
        wait_done(60);
        chk128("chain_block1", plain_text, P1);
        issue(C1, K1, 64'h0, P1);
        wait_done(60);
`ifdef TOP_SCR_BRD_CBC_CHAIN_EN
        chk128("chain_block2", plain_text, P1 ^ C1);
`else
        chk128("chain_block2", plain_text, P1);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/top_scr_brd.md
TOP_SCR_BRD -- requirements
Module: topScrBrd

Interface
REQ-001 The block SHALL have parameter Nb, default 4, columns in the state array; fixed at 4.
REQ-002 The block SHALL have parameter Nk, default 4, 32-bit key words; fixed at 4, AES-128 only.
REQ-003 The block SHALL have parameter Nr, default 10, number of cipher rounds; fixed at 10.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit, request to decrypt one block.
REQ-007 The block SHALL have port Iv, input, 64 bits, initialisation vector.
REQ-008 The block SHALL have port cipher, input, 128 bits (32*Nb), ciphertext block.
REQ-009 The block SHALL have port key, input, 128 bits (32*Nk), AES-128 cipher key.
REQ-010 The block SHALL have port plain_text, output, 128 bits, decrypted block.
REQ-011 The block SHALL have port ready, output, 1 bit, plain_text valid.

Function
REQ-012 The block SHALL use FIPS-197 byte order: bits [127:120] are state byte 0, column-major, for cipher, key and plain_text.
REQ-013 The block SHALL compute plain_text = InvCipher_AES128(cipher, key) XOR C, where C is the 128-bit chaining value.
REQ-014 For the first block after reset, C SHALL be {Iv, Iv}, i.e. Iv replicated into bits [127:64] and [63:0].
REQ-015 The FSM SHALL have three states: IDLE, KEYEXP and ROUND.
REQ-016 In IDLE, a high start sampled on a clock edge SHALL capture cipher, key and Iv, clear ready, and go to KEYEXP.
REQ-017 KEYEXP SHALL generate round keys 1..10 one per cycle (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36), store all 11 round keys, and go to ROUND after 10 cycles.
REQ-018 ROUND SHALL perform the FIPS-197 inverse cipher iteratively, one round per cycle, over 10 cycles:
- the first cycle also applies the initial AddRoundKey with round key 10;
- rounds apply InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns;
- the last round omits InvMixColumns.
REQ-019 On completion the block SHALL register plain_text, set ready high, and return to IDLE.
REQ-020 ready SHALL rise exactly 21 rising edges after the edge that accepted start.
REQ-021 ready and plain_text SHALL hold until the next accepted start; ready SHALL go low on the edge accepting a new start, while plain_text keeps its old value until the new result.
REQ-022 start SHALL be ignored while in KEYEXP or ROUND; cipher, key and Iv changes during processing SHALL have no effect.
REQ-023 start held high continuously SHALL start a new operation on each return to IDLE; a start in the same cycle ready is high SHALL be accepted.

Reset
REQ-024 While rst is low, the block SHALL asynchronously set state to IDLE, ready to 0, plain_text to 0, all round-key and state registers to 0, and mark the next block as "first block".
REQ-025 Reset asserted mid-operation SHALL abort the operation with no result produced.

Configuration
REQ-026 With macro TOP_SCR_BRD_CBC_CHAIN_EN defined, C SHALL be {Iv, Iv} for the first block after reset and the previously captured cipher for each later block (CBC chaining); Iv SHALL be ignored after the first block.
REQ-027 Without TOP_SCR_BRD_CBC_CHAIN_EN, C SHALL always be {Iv, Iv} as captured with each start, and no chaining register SHALL be built.

Verification
REQ-028 Reset check: rst low -> ready=0, plain_text=0; start high during reset -> no effect.
REQ-029 Known-answer test: key=000102030405060708090a0b0c0d0e0f, cipher=69c4e0d86a7b0430d8cdb78070b4c55a, Iv=0, start for 1 cycle -> 21 edges later ready=1, plain_text=00112233445566778899aabbccddeeff.
REQ-030 IV test: same key and cipher, Iv=2232859645102203 -> plain_text=2223a7a501454474aaab2f2d89cdccfc.
REQ-031 Busy test: start re-pulsed and cipher changed during KEYEXP/ROUND -> result unchanged and ready still exactly 21 edges after the first start.
REQ-032 Mid-operation reset: rst low at cycle 12 -> ready stays 0; a new start after release -> correct result at 21 edges.
REQ-033 Chaining test: with TOP_SCR_BRD_CBC_CHAIN_EN, Iv=0, run the REQ-029 block, then a second block with cipher=69c4e0d86a7b0430d8cdb78070b4c55a -> second plain_text = 00112233445566778899aabbccddeeff XOR 69c4e0d86a7b0430d8cdb78070b4c55a.
